// File: rtl/binary_search_pkg.sv
// Shared types and defaults for the binary search arbiter.
package binary_search_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESPOND
    } arb_state_t;

    localparam int DEF_TIMEOUT_CYC = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first request after ptr wins.
module rr_arbiter #(
    parameter  int N_REQ = 4,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_idx,
    output logic             any
);

    logic [ID_W-1:0] idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        idx       = '0;
        // Scan ptr+1 .. ptr+N_REQ so the last winner has lowest priority
        for (int k = 1; k <= N_REQ; k++) begin
            idx = ID_W'((int'(ptr) + k) % N_REQ);
            if (!any && req[idx]) begin
                any        = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/binary_search_arbiter.sv
// Shares one binary search engine among N_REQ requesters.
module binary_search_arbiter
    import binary_search_pkg::*;
#(
    parameter  int N_REQ       = 4,
    parameter  int DATA_W      = 8,
    parameter  int ARRAY_SIZE  = 10,
    parameter  int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    localparam int ID_W        = $clog2(N_REQ),
    localparam int IDX_W       = $clog2(ARRAY_SIZE)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_key,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ID_W-1:0]         rsp_id,
    output logic                    rsp_found,
    output logic                    rsp_timeout,
    output logic [IDX_W-1:0]        rsp_index,
    output logic                    eng_start,
    output logic [DATA_W-1:0]       eng_key,
    input  logic                    eng_found,
    input  logic                    eng_not_found,
    input  logic [IDX_W-1:0]        eng_center
);

    localparam int TIM_W = $clog2(TIMEOUT_CYC);
    localparam logic [TIM_W-1:0] TIM_LAST = TIM_W'(TIMEOUT_CYC - 1);

    arb_state_t        state;
    arb_state_t        state_nxt;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   cur_id;
    logic [ID_W-1:0]   grant_idx;
    logic [N_REQ-1:0]  grant;
    logic              any_req;
    logic              take;
    logic              timer_done;
    logic [DATA_W-1:0] cur_key;
    logic [TIM_W-1:0]  timer;

    rr_arbiter #(
        .N_REQ(N_REQ)
    ) u_rr (
        .req      (req_valid),
        .ptr      (rr_ptr),
        .grant    (grant),
        .grant_idx(grant_idx),
        .any      (any_req)
    );

    assign take       = (state == IDLE) && any_req;
    assign timer_done = (timer == TIM_LAST);
    assign req_ready  = (rst_n && state == IDLE) ? grant : '0;
    assign eng_start  = (state == ISSUE);
    assign eng_key    = cur_key;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (take) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT: begin
                if (eng_found || eng_not_found || timer_done)
                    state_nxt = RESPOND;
            end
            RESPOND: if (rsp_ready) state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr      <= ID_W'(N_REQ - 1);
            cur_id      <= '0;
            cur_key     <= '0;
            timer       <= '0;
            rsp_valid   <= 1'b0;
            rsp_id      <= '0;
            rsp_found   <= 1'b0;
            rsp_timeout <= 1'b0;
            rsp_index   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (take) begin
                        cur_id  <= grant_idx;
                        cur_key <= req_key[int'(grant_idx)*DATA_W +: DATA_W];
                    end
                end
                ISSUE: timer <= '0;
                WAIT: begin
                    timer <= timer + 1'b1;
                    // found beats not_found, either beats the timeout
                    if (eng_found) begin
                        rsp_valid   <= 1'b1;
                        rsp_id      <= cur_id;
                        rsp_found   <= 1'b1;
                        rsp_timeout <= 1'b0;
                        rsp_index   <= eng_center;
                    end else if (eng_not_found || timer_done) begin
                        rsp_valid   <= 1'b1;
                        rsp_id      <= cur_id;
                        rsp_found   <= 1'b0;
                        rsp_timeout <= !eng_not_found;
                        rsp_index   <= '0;
                    end
                end
                RESPOND: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rr_ptr    <= rsp_id;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_binary_search_arbiter.sv
// Scoreboard bench for binary_search_arbiter with a behavioural engine.
module tb_binary_search_arbiter;

    localparam int N = 4;
    localparam int DW = 8;
    localparam int M_FOUND = 0;
    localparam int M_NF = 1;
    localparam int M_BOTH = 2;
    localparam int M_SILENT = 3;

    typedef struct {
        int id;
        int found;
        int index;
        int tmo;
        int rise;
    } exp_t;

    logic          clk = 0;
    logic          rst_n;
    logic [N-1:0]  req_valid;
    logic [N*DW-1:0] req_key;
    logic [N-1:0]  req_ready;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [1:0]    rsp_id;
    logic          rsp_found;
    logic          rsp_timeout;
    logic [3:0]    rsp_index;
    logic          eng_start;
    logic [DW-1:0] eng_key;
    logic          eng_found;
    logic          eng_not_found;
    logic [3:0]    eng_center;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t q[$];
    int   glog[$];
    exp_t last_rsp;
    int   busy = 0;
    int   ptr = N - 1;
    int   exp_id = 0;
    int   exp_key = 0;
    int   start_due = -1;
    int   f_mode = -1;
    int   f_delay = 4;
    int   f_center = 7;
    int   stale_at = -10;

    binary_search_arbiter #(
        .N_REQ(N), .DATA_W(DW), .ARRAY_SIZE(10), .TIMEOUT_CYC(16)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_key(req_key), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_found(rsp_found), .rsp_timeout(rsp_timeout),
        .rsp_index(rsp_index), .eng_start(eng_start), .eng_key(eng_key),
        .eng_found(eng_found), .eng_not_found(eng_not_found),
        .eng_center(eng_center)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Behavioural engine: answers each start after a chosen delay
    initial begin : engine
        int cd;
        int md;
        int cen;
        bit active;
        exp_t e;
        active = 0;
        cd = 0; md = 0; cen = 0;
        eng_found = 0; eng_not_found = 0; eng_center = 0;
        forever begin
            @(negedge clk);
            eng_found = 0;
            eng_not_found = 0;
            eng_center = 0;
            if (!rst_n) begin
                active = 0;
                continue;
            end
            chk("eng_start", 32'(eng_start), 32'(cyc == start_due));
            if (eng_start) begin
                chk("eng_key", 32'(eng_key), 32'(exp_key));
                md  = (f_mode >= 0) ? f_mode : $urandom_range(0, 3);
                cd  = (f_mode >= 0) ? f_delay : $urandom_range(1, 12);
                cen = (f_mode >= 0) ? f_center : $urandom_range(0, 9);
                e.id    = exp_id;
                e.found = (md == M_FOUND || md == M_BOTH) ? 1 : 0;
                e.index = e.found ? cen : 0;
                e.tmo   = (md == M_SILENT) ? 1 : 0;
                e.rise  = cyc + ((md == M_SILENT) ? 17 : cd + 1);
                q.push_back(e);
                active = (md != M_SILENT);
            end else if (active) begin
                cd--;
                if (cd == 0) begin
                    active = 0;
                    eng_found     = (md == M_FOUND || md == M_BOTH);
                    eng_not_found = (md == M_NF || md == M_BOTH);
                    eng_center    = 4'(cen);
                end
            end
            if (cyc == stale_at) begin
                eng_found  = 1;
                eng_center = 4'd5;
            end
        end
    end

    // Monitor: arbitration model plus response scoreboard
    initial begin : monitor
        int win;
        int j;
        int exp_rdy;
        bit prev_v;
        exp_t e;
        prev_v = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy = 0;
                ptr = N - 1;
                start_due = -1;
                prev_v = 0;
                q.delete();
                chk("rst_req_ready", 32'(req_ready), 0);
                chk("rst_rsp_valid", 32'(rsp_valid), 0);
                chk("rst_eng_start", 32'(eng_start), 0);
                continue;
            end
            win = -1;
            if (!busy) begin
                for (int k = 1; k <= N; k++) begin
                    j = (ptr + k) % N;
                    if (win < 0 && req_valid[j]) win = j;
                end
            end
            exp_rdy = (win >= 0) ? (1 << win) : 0;
            chk("req_ready", 32'(req_ready), 32'(exp_rdy));
            if (win >= 0) begin
                busy = 1;
                exp_id = win;
                exp_key = int'(req_key[win*DW +: DW]);
                start_due = cyc + 1;
                glog.push_back(win);
            end
            if (rsp_valid) begin
                if (q.size() == 0) begin
                    chk("rsp_spurious", 1, 0);
                end else begin
                    e = q[0];
                    chk("rsp_id", 32'(rsp_id), 32'(e.id));
                    chk("rsp_found", 32'(rsp_found), 32'(e.found));
                    chk("rsp_index", 32'(rsp_index), 32'(e.index));
                    chk("rsp_timeout", 32'(rsp_timeout), 32'(e.tmo));
                    if (!prev_v) chk("rsp_latency", 32'(cyc), 32'(e.rise));
                    if (rsp_ready) begin
                        void'(q.pop_front());
                        last_rsp = e;
                        busy = 0;
                        ptr = e.id;
                    end
                end
            end
            prev_v = rsp_valid;
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 0;
        req_valid = '0;
        rsp_ready = 1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    task automatic wait_done(int budget);
        int n = 0;
        @(posedge clk);
        while ((busy != 0 || q.size() != 0) && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk("drain", 32'(busy != 0 || q.size() != 0), 0);
    endtask

    task automatic single(int i, logic [7:0] k);
        int n = 0;
        @(posedge clk); #1;
        req_key[i*DW +: DW] = k;
        req_valid[i] = 1;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready[i] && n < 50);
        chk("grant_wait", 32'(req_ready[i]), 1);
        @(posedge clk); #1;
        req_valid[i] = 0;
    endtask

    initial begin
        int n;
        rst_n = 0;
        req_valid = '0;
        req_key = '0;
        rsp_ready = 1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        chk("init_rsp_valid", 32'(rsp_valid), 0);
        chk("init_rsp_id", 32'(rsp_id), 0);
        chk("init_rsp_found", 32'(rsp_found), 0);
        chk("init_rsp_timeout", 32'(rsp_timeout), 0);
        chk("init_rsp_index", 32'(rsp_index), 0);
        chk("init_eng_key", 32'(eng_key), 0);

        // Lone requester 2, found after 4 cycles at center 7
        f_mode = M_FOUND; f_delay = 4; f_center = 7;
        single(2, 8'h33);
        wait_done(60);
        chk("t1_id", 32'(last_rsp.id), 2);
        chk("t1_found", 32'(last_rsp.found), 1);
        chk("t1_index", 32'(last_rsp.index), 7);
        chk("t1_tmo", 32'(last_rsp.tmo), 0);

        // All requesters valid from reset: strict rotation
        do_reset();
        glog.delete();
        f_mode = M_FOUND; f_delay = 2;
        @(posedge clk); #1;
        req_key = $urandom;
        req_valid = '1;
        n = 0;
        while (glog.size() < 5 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1 req_valid = '0;
        wait_done(60);
        chk("rot_count", 32'(glog.size() >= 5), 1);
        if (glog.size() >= 5) begin
            chk("rot0", 32'(glog[0]), 0);
            chk("rot1", 32'(glog[1]), 1);
            chk("rot2", 32'(glog[2]), 2);
            chk("rot3", 32'(glog[3]), 3);
            chk("rot4", 32'(glog[4]), 0);
        end

        // Simultaneous found and not_found: found wins
        f_mode = M_BOTH; f_delay = 3; f_center = 9;
        single(1, 8'h5a);
        wait_done(60);
        chk("both_found", 32'(last_rsp.found), 1);
        chk("both_index", 32'(last_rsp.index), 9);

        f_mode = M_NF; f_delay = 5; f_center = 6;
        single(0, 8'h11);
        wait_done(60);
        chk("nf_found", 32'(last_rsp.found), 0);
        chk("nf_index", 32'(last_rsp.index), 0);

        // Silent engine: timeout
        f_mode = M_SILENT;
        single(3, 8'hc4);
        wait_done(80);
        chk("to_tmo", 32'(last_rsp.tmo), 1);
        chk("to_found", 32'(last_rsp.found), 0);

        // Response backpressure with competing requesters
        f_mode = M_FOUND; f_delay = 3; f_center = 4;
        @(posedge clk); #1 rsp_ready = 0;
        single(0, 8'h77);
        req_valid = 4'b1110;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < 50);
        chk("bp_valid", 32'(rsp_valid), 1);
        repeat (10) @(negedge clk);
        chk("bp_hold", 32'(rsp_valid), 1);
        @(posedge clk); #1;
        rsp_ready = 1;
        req_valid = '0;
        wait_done(20);
        chk("bp_id", 32'(last_rsp.id), 0);

        // Reset during WAIT, then a stale found in IDLE
        f_mode = M_SILENT;
        single(2, 8'h9e);
        repeat (4) @(posedge clk);
        #1 rst_n = 0;
        req_valid = '1;
        #1;
        chk("mid_req_ready", 32'(req_ready), 0);
        chk("mid_rsp_valid", 32'(rsp_valid), 0);
        chk("mid_rsp_id", 32'(rsp_id), 0);
        chk("mid_rsp_found", 32'(rsp_found), 0);
        chk("mid_rsp_tmo", 32'(rsp_timeout), 0);
        chk("mid_rsp_index", 32'(rsp_index), 0);
        chk("mid_eng_start", 32'(eng_start), 0);
        chk("mid_eng_key", 32'(eng_key), 0);
        @(posedge clk); #1;
        req_valid = '0;
        rst_n = 1;
        stale_at = cyc + 2;
        repeat (8) begin
            @(negedge clk);
            chk("stale_rsp", 32'(rsp_valid), 0);
        end

        // Random traffic
        f_mode = -1;
        repeat (400) begin
            @(posedge clk); #1;
            req_valid = N'($urandom);
            req_key = $urandom;
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #1;
        req_valid = '0;
        rsp_ready = 1;
        wait_done(100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
